// File: rtl/traffic_light_monitor.sv
// traffic_light_monitor: checks light-bus exclusivity, phase order and dwell, and latches the first fault (sticky).
// Latency: outputs registered one clk after the sample; no backpressure. LIGHT_MON_STATS_EN enables round_cnt.
module traffic_light_monitor #(
  parameter int PHASE_CYCLES = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] n_lights,
  input  logic [1:0] s_lights,
  input  logic [1:0] e_lights,
  input  logic [1:0] w_lights,
  output logic       in_sync,
  output logic [2:0] phase,
  output logic       fault,
  output logic [2:0] fault_code,
  output logic [7:0] round_cnt
);

  localparam int DW = $clog2(PHASE_CYCLES + 2);
  localparam logic [DW-1:0] DWELL_REQ = DW'(PHASE_CYCLES);

  typedef enum logic [1:0] {IDLE, TRACK, FAULT} state_t;

  state_t        state_q, state_nxt;
  logic [2:0]    phase_q, phase_nxt;
  logic [DW-1:0] dwell_q, dwell_nxt;
  logic [2:0]    code_q, code_nxt, code_det;
  logic          prev_ph0_q, prev_ph0_nxt;

  logic [3:0] non_red;
  logic [3:0] illegal;
  logic       any_illegal, multi, all_red, cur_valid;
  logic [2:0] cur_phase;
  logic [2:0] phase_succ;

  assign non_red = {w_lights != 2'b00, e_lights != 2'b00, s_lights != 2'b00, n_lights != 2'b00};
  assign illegal = {w_lights == 2'b11, e_lights == 2'b11, s_lights == 2'b11, n_lights == 2'b11};
  assign any_illegal = |illegal;
  assign multi       = (non_red & (non_red - 4'd1)) != 4'd0;
  assign all_red     = non_red == 4'd0;
  assign cur_valid   = !any_illegal && !multi && !all_red;
  assign phase_succ  = phase_q + 3'd1;

  always_comb begin
    cur_phase = 3'd0;
    if (non_red[0])      cur_phase = {2'd0, n_lights == 2'b01};
    else if (non_red[1]) cur_phase = {2'd1, s_lights == 2'b01};
    else if (non_red[2]) cur_phase = {2'd2, e_lights == 2'b01};
    else if (non_red[3]) cur_phase = {2'd3, w_lights == 2'b01};
  end

  // Priority chain: lowest code wins when several checks trip together.
  always_comb begin
    code_det = 3'd0;
    if (any_illegal)             code_det = 3'd1;
    else if (multi)              code_det = 3'd2;
    else if (state_q == TRACK) begin
      if (all_red)               code_det = 3'd3;
      else if (cur_phase != phase_q && cur_phase != phase_succ)
                                 code_det = 3'd4;
      else if (cur_phase != phase_q && dwell_q != DWELL_REQ)
                                 code_det = 3'd5;
      else if (cur_phase == phase_q && dwell_q == DWELL_REQ)
                                 code_det = 3'd6;
    end
  end

  assign prev_ph0_nxt = cur_valid && (cur_phase == 3'd0);

  always_comb begin
    state_nxt = state_q;
    phase_nxt = phase_q;
    dwell_nxt = dwell_q;
    code_nxt  = code_q;
    case (state_q)
      IDLE: begin
        if (code_det != 3'd0) begin
          state_nxt = FAULT;
          code_nxt  = code_det;
        end else if (prev_ph0_nxt && !prev_ph0_q) begin
          state_nxt = TRACK;
          phase_nxt = 3'd0;
          dwell_nxt = DW'(1);
        end
      end
      TRACK: begin
        if (code_det != 3'd0) begin
          state_nxt = FAULT;
          code_nxt  = code_det;
        end else if (cur_phase == phase_q) begin
          if (dwell_q != '1) dwell_nxt = dwell_q + DW'(1);
        end else begin
          phase_nxt = cur_phase;
          dwell_nxt = DW'(1);
        end
      end
      default: begin
        state_nxt = FAULT;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= IDLE;
      phase_q    <= 3'd0;
      dwell_q    <= '0;
      code_q     <= 3'd0;
      prev_ph0_q <= 1'b0;
    end else begin
      state_q    <= state_nxt;
      phase_q    <= phase_nxt;
      dwell_q    <= dwell_nxt;
      code_q     <= code_nxt;
      prev_ph0_q <= prev_ph0_nxt;
    end
  end

  assign in_sync    = state_q == TRACK;
  assign fault      = state_q == FAULT;
  assign phase      = phase_q;
  assign fault_code = code_q;

`ifdef LIGHT_MON_STATS_EN
  logic [7:0] round_q;

  // A round closes on the accepted W_Y -> N change.
  always_ff @(posedge clk) begin
    if (!rst) begin
      round_q <= 8'd0;
    end else if (state_q == TRACK && state_nxt == TRACK &&
                 phase_q == 3'd7 && phase_nxt == 3'd0) begin
      round_q <= round_q + 8'd1;
    end
  end

  assign round_cnt = round_q;
`else
  assign round_cnt = 8'd0;
`endif

endmodule

// File: tb/tb_traffic_light_monitor.sv
// Directed bench for traffic_light_monitor: scoreboard of expected outputs, compared 1ns after each edge.
module tb_traffic_light_monitor;

  typedef struct packed {
    logic       sync;
    logic [2:0] ph;
    logic       flt;
    logic [2:0] code;
  } obs_t;

`ifdef LIGHT_MON_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [1:0] n_l = 2'b00, s_l = 2'b00, e_l = 2'b00, w_l = 2'b00;
  logic       in_sync, fault;
  logic [2:0] phase, fault_code;
  logic [7:0] round_cnt;

  obs_t exp_q[$];
  int   errors = 0;
  int   checks = 0;

  traffic_light_monitor #(.PHASE_CYCLES(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .n_lights  (n_l),
    .s_lights  (s_l),
    .e_lights  (e_l),
    .w_lights  (w_l),
    .in_sync   (in_sync),
    .phase     (phase),
    .fault     (fault),
    .fault_code(fault_code),
    .round_cnt (round_cnt)
  );

  always #5 clk = ~clk;

  function automatic obs_t mk(input logic s, input logic [2:0] p, input logic f, input logic [2:0] c);
    obs_t o;
    o.sync = s; o.ph = p; o.flt = f; o.code = c;
    return o;
  endfunction

  // Light pattern {n,s,e,w} for a phase index.
  function automatic logic [7:0] lt(input int ph);
    logic [1:0] v;
    logic [7:0] r;
    v = ph[0] ? 2'b01 : 2'b10;
    r = 8'h00;
    case (ph / 2)
      0:       r[7:6] = v;
      1:       r[5:4] = v;
      2:       r[3:2] = v;
      default: r[1:0] = v;
    endcase
    return r;
  endfunction

  task automatic step(input logic [7:0] l, input obs_t e, input string tag);
    obs_t got, want;
    @(negedge clk);
    {n_l, s_l, e_l, w_l} = l;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    got  = {in_sync, phase, fault, fault_code};
    want = exp_q.pop_front();
    checks++;
    assert (got === want) else begin
      errors++;
      $error("FAIL %s: got sync=%0b ph=%0d flt=%0b code=%0d, want sync=%0b ph=%0d flt=%0b code=%0d",
             tag, got.sync, got.ph, got.flt, got.code, want.sync, want.ph, want.flt, want.code);
    end
  endtask

  task automatic chk_rc(input logic [7:0] want, input string tag);
    checks++;
    assert (round_cnt === want) else begin
      errors++;
      $error("FAIL %s: round_cnt got=%0d want=%0d", tag, round_cnt, want);
    end
  endtask

  task automatic reset_cycle(input string tag);
    rst = 1'b0;
    step(8'h00, mk(0, 0, 0, 0), tag);
    rst = 1'b1;
  endtask

  // From a fresh lock: full 8-cycle phases 0..target-1, then cyc cycles of target.
  task automatic nominal_to(input int target, input int cyc, input string tag);
    for (int p = 0; p < target; p++)
      for (int c = 0; c < 8; c++) step(lt(p), mk(1, 3'(p), 0, 0), tag);
    for (int c = 0; c < cyc; c++) step(lt(target), mk(1, 3'(target), 0, 0), tag);
  endtask

  initial begin
    // 1: reset, idle all-red, two full rounds plus the closing N green
    rst = 1'b0;
    step(8'h00, mk(0, 0, 0, 0), "rst_a");
    step(8'h00, mk(0, 0, 0, 0), "rst_b");
    chk_rc(8'd0, "rc_reset");
    rst = 1'b1;
    for (int i = 0; i < 3; i++) step(8'h00, mk(0, 0, 0, 0), "idle_red");
    for (int r = 0; r < 2; r++) nominal_to(7, 8, "round");
    step(lt(0), mk(1, 0, 0, 0), "wrap");
    chk_rc(STATS ? 8'd2 : 8'd0, "rc_two");

    // 2: second approach non-red during S green, then sticky over an illegal
    for (int c = 0; c < 7; c++) step(lt(0), mk(1, 0, 0, 0), "t2_n");
    for (int c = 0; c < 8; c++) step(lt(1), mk(1, 1, 0, 0), "t2_ny");
    for (int c = 0; c < 3; c++) step(lt(2), mk(1, 2, 0, 0), "t2_s");
    step(8'b10_10_00_00, mk(0, 2, 1, 2), "code2");
    step(8'b10_10_11_00, mk(0, 2, 1, 2), "code2_sticky");
    chk_rc(STATS ? 8'd2 : 8'd0, "rc_frozen");

    reset_cycle("rst_t2b");
    nominal_to(2, 3, "t2b");
    step(8'b10_10_11_00, mk(0, 2, 1, 1), "code1_wins");

    // 3: order and dwell faults
    reset_cycle("rst_t3a");
    nominal_to(0, 8, "t3a");
    step(lt(2), mk(0, 0, 1, 4), "code4");
    reset_cycle("rst_t3b");
    nominal_to(1, 5, "t3b");
    step(lt(2), mk(0, 1, 1, 5), "code5");
    reset_cycle("rst_t3c");
    nominal_to(2, 8, "t3c");
    step(lt(2), mk(0, 2, 1, 6), "code6");

    // 4: all-red while tracking
    reset_cycle("rst_t4a");
    nominal_to(4, 2, "t4a");
    step(8'h00, mk(0, 4, 1, 3), "code3");
    step(lt(4), mk(0, 4, 1, 3), "code3_sticky");

    // 6: reset out of FAULT, then relock
    reset_cycle("rst_from_fault");
    chk_rc(8'd0, "rc_cleared");
    nominal_to(7, 8, "relock");
    step(lt(0), mk(1, 0, 0, 0), "relock_wrap");
    chk_rc(STATS ? 8'd1 : 8'd0, "rc_relock");

    // 4b: idle all-red is legal; illegal value faults even in IDLE
    reset_cycle("rst_t4b");
    for (int i = 0; i < 10; i++) step(8'h00, mk(0, 0, 0, 0), "idle_red10");
    step(8'b00_00_11_00, mk(0, 0, 1, 1), "idle_code1");

    // 5: reset released mid-S, lock only on the next N green edge
    rst = 1'b0;
    step(lt(2), mk(0, 0, 0, 0), "t5_rst");
    rst = 1'b1;
    for (int c = 0; c < 5; c++) step(lt(2), mk(0, 0, 0, 0), "t5_s");
    for (int p = 3; p < 8; p++)
      for (int c = 0; c < 8; c++) step(lt(p), mk(0, 0, 0, 0), "t5_idle");
    nominal_to(1, 3, "t5_lock");
    chk_rc(8'd0, "rc_t5");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
